mem_responder: RTL

- Memory-side responder for the core's instruction-fetch and data-memory request interfaces.
- Serves both ports from one shared single-port word array, so only one access is in progress at a time.
- Fixed priority: data port first, then instruction port. Accesses take a configurable number of wait cycles.
- Drives per-port stall outputs that the pipeline controller uses to freeze the requesting stage.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one shared single-port word array serves the data port
// (priority) and the instruction port, with a fixed number of stall cycles per access.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;

    logic [31:0] mem_array [DEPTH];

    logic        mem_req;
    logic        d_done;
    logic        i_done;
    logic        load_d;
    logic        load_i;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign mem_req = mem_ren | mem_wen;
    assign d_done  = (state_q == D_ACC) && (cnt_q == 4'd0);
    assign i_done  = (state_q == I_ACC) && (cnt_q == 4'd0);
    assign rd_word = mem_array[idx_q];

    // Byte-offset and above-depth address bits are deliberately ignored (aliasing).
    assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0],
                                mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        load_d  = 1'b0;
        load_i  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    load_d = 1'b1;
                end else if (inst_ren) begin
                    load_i = 1'b1;
                end
            end
            D_ACC: begin
                if (cnt_q != 4'd0) begin
                    if (!mem_req) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (inst_ren) begin
                    load_i = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            I_ACC: begin
                if (cnt_q != 4'd0) begin
                    if (!inst_ren) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (mem_req) begin
                    load_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // A finishing access hands over straight to the waiting port, no idle bubble.
        if (load_d) begin
            state_d = D_ACC;
            cnt_d   = CNT_LOAD;
            idx_d   = mem_addr[ADDR_WIDTH+1:2];
            wdata_d = mem_wdata;
            wr_d    = mem_wen;
        end else if (load_i) begin
            state_d = I_ACC;
            cnt_d   = CNT_LOAD;
            idx_d   = inst_addr[ADDR_WIDTH+1:2];
            wr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // Contents survive reset; a reset forces IDLE so no pending write can commit.
    always_ff @(posedge clk) begin
        if (d_done && wr_q) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    assign inst_data  = i_done ? rd_word : 32'd0;
    assign mem_rdata  = (d_done && !wr_q) ? rd_word : 32'd0;
    assign mem_stall  = mem_req & ~d_done;
    assign inst_stall = inst_ren & ~i_done;

endmodule
